// File: rtl/lsh_top_level.sv
// lsh_top_level: min-hash sketching of a nucleotide window, bucketed
// reference table insert, per-window voting and argmax selection.
module lsh_top_level #(
   parameter int WINDOW_SIZE              = 128,
   parameter int KMER_SIZE                = 16,
   parameter int SKETCH_SIZE              = 16,
   parameter int NUM_OF_BUCKETS           = 256,
   parameter int BUCKET_SIZE              = 16,
   parameter int MAX_WINDOWS_IN_REFERENCE = 512,
   parameter int MAX_WINDOWS_IN_READ      = 16,
   parameter int WINDOWS_PER_QUERY        = 1
) (
   input  logic               clk,
   input  logic               reset_hash_table,
   input  logic               reset_window_hasher,
   input  logic               reset_stats,
   input  logic [1:0]         window [0:WINDOW_SIZE-1],
   input  logic [31:0]        window_id,
   input  logic               ready_for_hashing,
   input  logic               is_insert,
   input  logic               is_query,
   input  logic               calculate_matched_window,
   output logic               hashing_is_done,
   output logic signed [31:0] matched_window_id
);

   localparam int N    = WINDOW_SIZE - KMER_SIZE + 1;
   localparam int WAW  = $clog2(WINDOW_SIZE);
   localparam int XW   = $clog2(N + 1);
   localparam int BW   = $clog2(NUM_OF_BUCKETS);
   localparam int IW   = $clog2(MAX_WINDOWS_IN_REFERENCE);
   localparam int CW   = $clog2(BUCKET_SIZE + 1);
   localparam int SW   = $clog2(BUCKET_SIZE);
   // Reserved parameter; multiplied by zero so it never alters sizing.
   localparam int VMAX = SKETCH_SIZE * MAX_WINDOWS_IN_READ
                       + 0 * WINDOWS_PER_QUERY;
   localparam int VW   = $clog2(VMAX + 1);
   localparam int SUMW = VW + 1;
   localparam int MAXW = MAX_WINDOWS_IN_REFERENCE;

   localparam logic [31:0] SEED_MUL = 32'h85EBCA6B;
   localparam logic [31:0] GOLD     = 32'h9E3779B1;

   logic [XW-1:0]      idx_q;
   logic               done_q;
   logic [31:0]        min_q [SKETCH_SIZE];
   logic [31:0]        min_d [SKETCH_SIZE];
   logic [31:0]        hash  [SKETCH_SIZE];
   logic [31:0]        kmer;
   logic [BW-1:0]      bkt   [SKETCH_SIZE];

   logic [IW-1:0]      tab_q [NUM_OF_BUCKETS][BUCKET_SIZE];
   logic [CW-1:0]      cnt_q [NUM_OF_BUCKETS];
   logic [SKETCH_SIZE-1:0] ins_en;

   logic               ins_prev_q;
   logic               qry_prev_q;
   logic               ins_fire;
   logic               qry_fire;

   logic [MAXW-1:0]    hit     [SKETCH_SIZE];
   logic [SUMW-1:0]    vsum    [MAXW];
   logic [VW-1:0]      votes_q [MAXW];
   logic [VW-1:0]      votes_d [MAXW];

   logic [VW-1:0]      best_v;
   logic signed [31:0] best_id;
   logic signed [31:0] match_q;

   // Assemble the current k-mer, most significant nucleotide first.
   always_comb begin
      kmer = '0;
      for (int t = 0; t < KMER_SIZE; t++)
         kmer = {kmer[29:0], window[WAW'(int'(idx_q) + t)]};
   end

   // All hash functions in parallel and the running-minimum update.
   always_comb begin
      for (int i = 0; i < SKETCH_SIZE; i++) begin
         hash[i]  = (kmer ^ (32'(i) * SEED_MUL)) * GOLD;
         min_d[i] = (hash[i] < min_q[i]) ? hash[i] : min_q[i];
         bkt[i]   = min_q[i][31 -: BW];
      end
   end

   // Hasher: one k-mer per enabled cycle until the window is covered.
   always_ff @(posedge clk) begin
      if (reset_window_hasher) begin
         idx_q  <= '0;
         done_q <= 1'b0;
         min_q  <= '{default: '1};
      end else if (ready_for_hashing && !done_q) begin
         min_q  <= min_d;
         idx_q  <= idx_q + XW'(1);
         done_q <= (idx_q == XW'(N - 1));
      end
   end

   // Previous values of the operation strobes for edge detection.
   always_ff @(posedge clk) begin
      ins_prev_q <= is_insert;
      qry_prev_q <= is_query;
   end

   assign ins_fire = is_insert && !ins_prev_q
                  && (window_id < 32'(MAXW));
   assign qry_fire = is_query && !qry_prev_q;

   // Per-element append decision. A repeated bucket among earlier
   // elements already holds window_id as its last entry (or was
   // full), so only the first occurrence of a bucket may append.
   always_comb begin
      for (int i = 0; i < SKETCH_SIZE; i++) begin
         ins_en[i] = (cnt_q[bkt[i]] != CW'(BUCKET_SIZE))
            && !((cnt_q[bkt[i]] != '0)
              && (tab_q[bkt[i]][SW'(cnt_q[bkt[i]]) - SW'(1)]
                  == window_id[IW-1:0]));
         for (int k = 0; k < i; k++)
            if (bkt[k] == bkt[i])
               ins_en[i] = 1'b0;
      end
   end

   // Bucket table: reset clears counts, insert appends the id.
   always_ff @(posedge clk) begin
      if (reset_hash_table) begin
         cnt_q <= '{default: '0};
      end else if (ins_fire) begin
         for (int i = 0; i < SKETCH_SIZE; i++) begin
            if (ins_en[i]) begin
               tab_q[bkt[i]][SW'(cnt_q[bkt[i]])] <= window_id[IW-1:0];
               cnt_q[bkt[i]] <= cnt_q[bkt[i]] + CW'(1);
            end
         end
      end
   end

   // Membership of each reference id in each element's bucket.
   always_comb begin
      for (int i = 0; i < SKETCH_SIZE; i++) begin
         hit[i] = '0;
         for (int s = 0; s < BUCKET_SIZE; s++)
            if (CW'(s) < cnt_q[bkt[i]])
               hit[i][tab_q[bkt[i]][s]] = 1'b1;
      end
   end

   // Saturating vote increment for every reference id.
   always_comb begin
      for (int j = 0; j < MAXW; j++) begin
         vsum[j] = SUMW'(votes_q[j]);
         for (int i = 0; i < SKETCH_SIZE; i++)
            vsum[j] = vsum[j] + SUMW'(hit[i][j]);
         votes_d[j] = (vsum[j] > SUMW'(VMAX))
                    ? VW'(VMAX) : vsum[j][VW-1:0];
      end
   end

   // Vote counters: cleared by reset_stats, bumped once per query edge.
   always_ff @(posedge clk) begin
      if (reset_stats)
         votes_q <= '{default: '0};
      else if (qry_fire)
         votes_q <= votes_d;
   end

   // Argmax with strict compare so ties keep the lowest id.
   always_comb begin
      best_v  = '0;
      best_id = -32'sd1;
      for (int j = 0; j < MAXW; j++) begin
         if (votes_q[j] > best_v) begin
            best_v  = votes_q[j];
            best_id = 32'(j);
         end
      end
   end

   // Registered match result, held between calculations.
   always_ff @(posedge clk) begin
      if (reset_stats)
         match_q <= -32'sd1;
      else if (calculate_matched_window)
         match_q <= best_id;
   end

   assign hashing_is_done   = done_q;
   assign matched_window_id = match_q;

endmodule

// File: tb/tb_lsh_top_level.sv
// tb_lsh_top_level: random and directed stimulus for lsh_top_level
// against a queue-based reference model of sketch, table and votes.
module tb_lsh_top_level;

   logic               clk = 1'b0;
   logic               reset_hash_table = 1'b0;
   logic               reset_window_hasher = 1'b0;
   logic               reset_stats = 1'b0;
   logic [1:0]         win [0:127];
   logic [31:0]        window_id = '0;
   logic               ready_for_hashing = 1'b0;
   logic               is_insert = 1'b0;
   logic               is_query = 1'b0;
   logic               calculate_matched_window = 1'b0;
   logic               hashing_is_done;
   logic signed [31:0] matched_window_id;

   always #5 clk = ~clk;

   lsh_top_level dut (
      .clk                      (clk),
      .reset_hash_table         (reset_hash_table),
      .reset_window_hasher      (reset_window_hasher),
      .reset_stats              (reset_stats),
      .window                   (win),
      .window_id                (window_id),
      .ready_for_hashing        (ready_for_hashing),
      .is_insert                (is_insert),
      .is_query                 (is_query),
      .calculate_matched_window (calculate_matched_window),
      .hashing_is_done          (hashing_is_done),
      .matched_window_id        (matched_window_id)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] m_sk [16];
   int          m_tbl [256][$];
   int          m_votes [512];
   logic [1:0]  wins [10][128];

   task automatic chk(string tag, longint got, longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference sketch: min over all k-mers of every hash function.
   task automatic m_sketch;
      logic [31:0] k, h, s;
      for (int i = 0; i < 16; i++) m_sk[i] = 32'hFFFFFFFF;
      for (int p = 0; p < 113; p++) begin
         k = 0;
         for (int t = 0; t < 16; t++) k = (k << 2) | 32'(win[p + t]);
         for (int i = 0; i < 16; i++) begin
            s = 32'(i) * 32'h85EBCA6B;
            h = (k ^ s) * 32'h9E3779B1;
            if (h < m_sk[i]) m_sk[i] = h;
         end
      end
   endtask

   task automatic m_insert(int id);
      int b;
      if (id >= 512) return;
      for (int i = 0; i < 16; i++) begin
         b = int'(m_sk[i][31:24]);
         if (m_tbl[b].size() < 16 &&
             (m_tbl[b].size() == 0 || m_tbl[b][$] != id))
            m_tbl[b].push_back(id);
      end
   endtask

   task automatic m_query;
      int inc [512];
      bit seen [512];
      int b;
      foreach (inc[j]) inc[j] = 0;
      for (int i = 0; i < 16; i++) begin
         foreach (seen[j]) seen[j] = 0;
         b = int'(m_sk[i][31:24]);
         foreach (m_tbl[b][e]) begin
            if (!seen[m_tbl[b][e]]) begin
               seen[m_tbl[b][e]] = 1;
               inc[m_tbl[b][e]]++;
            end
         end
      end
      foreach (m_votes[j]) begin
         m_votes[j] += inc[j];
         if (m_votes[j] > 256) m_votes[j] = 256;
      end
   endtask

   function automatic int m_argmax();
      int best = -1;
      int bv = 0;
      for (int j = 0; j < 512; j++)
         if (m_votes[j] > bv) begin
            bv = m_votes[j];
            best = j;
         end
      return best;
   endfunction

   task automatic check_table(string tag);
      int bad = 0;
      for (int b = 0; b < 256; b++) begin
         if (int'(dut.cnt_q[b]) != m_tbl[b].size()) bad++;
         else foreach (m_tbl[b][s])
            if (int'(dut.tab_q[b][s]) != m_tbl[b][s]) bad++;
      end
      chk(tag, bad, 0);
   endtask

   task automatic check_votes(string tag);
      int bad = 0;
      for (int j = 0; j < 512; j++)
         if (int'(dut.votes_q[j]) != m_votes[j]) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic check_sketch(string tag);
      int bad = 0;
      for (int i = 0; i < 16; i++)
         if (dut.min_q[i] != m_sk[i]) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic do_hash(bit pauses);
      reset_window_hasher = 1'b1;
      tick;
      reset_window_hasher = 1'b0;
      m_sketch();
      for (int c = 0; c < 600; c++) begin
         ready_for_hashing = pauses ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick;
         if (hashing_is_done) break;
      end
      ready_for_hashing = 1'b0;
      chk("hash_done", hashing_is_done, 1);
      check_sketch("sketch");
   endtask

   task automatic pulse_insert(int id, int hold);
      window_id = 32'(id);
      is_insert = 1'b1;
      repeat (hold) tick;
      is_insert = 1'b0;
      tick;
      m_insert(id);
   endtask

   task automatic pulse_query(int hold);
      is_query = 1'b1;
      repeat (hold) tick;
      is_query = 1'b0;
      tick;
      m_query();
   endtask

   task automatic calc(string tag);
      calculate_matched_window = 1'b1;
      tick;
      calculate_matched_window = 1'b0;
      chk(tag, matched_window_id, m_argmax());
   endtask

   task automatic rst_stats;
      reset_stats = 1'b1;
      tick;
      reset_stats = 1'b0;
      foreach (m_votes[j]) m_votes[j] = 0;
   endtask

   task automatic rst_table;
      reset_hash_table = 1'b1;
      tick;
      reset_hash_table = 1'b0;
      for (int b = 0; b < 256; b++) m_tbl[b].delete();
   endtask

   initial begin
      foreach (win[p]) win[p] = 2'b00;
      foreach (m_votes[j]) m_votes[j] = 0;
      tick;
      reset_hash_table = 1'b1;
      reset_window_hasher = 1'b1;
      reset_stats = 1'b1;
      tick;
      reset_hash_table = 1'b0;
      reset_window_hasher = 1'b0;
      reset_stats = 1'b0;
      chk("rst_done", hashing_is_done, 0);
      chk("rst_match", matched_window_id, -1);
      chk("rst_min0", dut.min_q[0], 32'hFFFFFFFF);
      check_table("rst_table");
      check_votes("rst_votes");

      // Exact hashing latency with ready held high.
      foreach (win[p]) win[p] = 2'($urandom);
      m_sketch();
      ready_for_hashing = 1'b1;
      for (int e = 1; e <= 120; e++) begin
         tick;
         if (e == 112) chk("done_e112", hashing_is_done, 0);
         if (e == 113) chk("done_e113", hashing_is_done, 1);
         if (e == 120) chk("done_e120", hashing_is_done, 1);
      end
      ready_for_hashing = 1'b0;
      check_sketch("lat_sketch");
      reset_window_hasher = 1'b1;
      tick;
      reset_window_hasher = 1'b0;
      chk("done_clr", hashing_is_done, 0);

      // Query on an empty table.
      foreach (win[p]) win[p] = 2'b00;
      do_hash(1'b0);
      pulse_query(2);
      calc("empty_match");
      chk("empty_neg", matched_window_id, -1);

      // Single insert held two cycles, then vote.
      pulse_insert(5, 2);
      check_table("ins5_table");
      chk("ins5_dedup", dut.cnt_q[m_sk[0][31:24]], 1);
      rst_stats();
      pulse_query(1);
      chk("votes5", dut.votes_q[5], 16);
      check_votes("q5_votes");
      calc("match5");
      chk("match5_const", matched_window_id, 5);
      repeat (3) tick;
      chk("match_hold", matched_window_id, 5);

      // Bucket capacity with ids 0..16.
      rst_table();
      rst_stats();
      for (int id = 0; id <= 16; id++) pulse_insert(id, 1);
      check_table("cap_table");
      chk("cap_cnt", dut.cnt_q[m_sk[0][31:24]], 16);
      pulse_query(1);
      chk("cap_v16", dut.votes_q[16], 0);
      chk("cap_v0", dut.votes_q[0], 16);
      calc("cap_match");
      chk("cap_tie", matched_window_id, 0);

      // Insert and query on the same edge.
      rst_table();
      rst_stats();
      pulse_insert(3, 1);
      window_id = 32'd4;
      is_insert = 1'b1;
      is_query = 1'b1;
      tick;
      is_insert = 1'b0;
      is_query = 1'b0;
      tick;
      m_query();
      m_insert(4);
      chk("same_v3", dut.votes_q[3], 16);
      chk("same_v4", dut.votes_q[4], 0);
      check_table("same_table");

      // Ten random reference windows, query with window 7.
      rst_table();
      rst_stats();
      for (int k = 0; k < 10; k++) begin
         foreach (win[p]) win[p] = 2'($urandom);
         wins[k] = win;
         do_hash(1'b1);
         pulse_insert(k, 1);
      end
      check_table("rand_table");
      win = wins[7];
      do_hash(1'b1);
      pulse_query(1);
      check_votes("rand_votes");
      calc("rand_match");
      chk("rand_is7", matched_window_id, 7);
      for (int r = 0; r < 17; r++) pulse_query(1);
      chk("sat_v7", dut.votes_q[7], 256);
      check_votes("sat_votes");
      rst_stats();
      chk("stats_clr", matched_window_id, -1);

      // Out-of-range id and a mid-sequence table reset.
      pulse_insert(600, 1);
      check_table("id600_table");
      foreach (win[p]) win[p] = 2'($urandom);
      do_hash(1'b1);
      pulse_insert(20, 1);
      rst_table();
      rst_stats();
      pulse_query(1);
      calc("rtab_match");
      chk("rtab_neg", matched_window_id, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lsh_top_level.md
# lsh_top_level

Locality-sensitive-hashing read-mapping engine. It min-hash sketches a window of nucleotides and either inserts the sketch into a bucketed hash table of reference windows or uses it to vote for reference windows. On request it reports the reference window with the most votes. It is the top of the LSH datapath and is driven by a host or sequencer that supplies windows and control pulses.

## Interface
- WINDOW_SIZE, 128: nucleotides per window.
- KMER_SIZE, 16: nucleotides per k-mer, at most 16.
- SKETCH_SIZE, 16: number of min-hash functions.
- NUM_OF_BUCKETS, 256: hash-table buckets, a power of 2.
- BUCKET_SIZE, 16: window-id slots per bucket.
- MAX_WINDOWS_IN_REFERENCE, 512: number of vote counters and the window-id range.
- MAX_WINDOWS_IN_READ, 16: sizes the vote counter width.
- WINDOWS_PER_QUERY, 1: reserved; it has no functional effect.
- Clocking and reset (already decided): one clock, `clk`. All resets are synchronous and active-high.
- clk  in  1  clock; everything updates on the rising edge.
- reset_hash_table  in  1  clears all bucket counts.
- reset_window_hasher  in  1  clears the sketch, the k-mer index and `hashing_is_done`.
- reset_stats  in  1  clears all vote counters and sets `matched_window_id` to -1.
- window  in  2 x WINDOW_SIZE  unpacked array [0:WINDOW_SIZE-1] with A=00, C=01, G=10, T=11. It is held stable while hashing.
- window_id  in  32  id of the current window; used by insert.
- ready_for_hashing  in  1  level; enables k-mer processing.
- is_insert  in  1  a rising edge triggers one insert.
- is_query  in  1  a rising edge triggers one vote.
- calculate_matched_window  in  1  level; triggers the argmax.
- hashing_is_done  out  1  sketch complete. Reset value 0.
- matched_window_id  out  signed 32  best window, or -1. Reset value -1.

## Operation
- Constants:
  - N = WINDOW_SIZE-KMER_SIZE+1 (113 k-mers by default).
  - B = log2(NUM_OF_BUCKETS).
- K-mer p, for p in 0..N-1, is the concatenation {window[p],...,window[p+KMER_SIZE-1]}. window[p] is most significant, and the result is zero-extended to 32 bits.
- Hash i, for i in 0..SKETCH_SIZE-1: h_i(k) = ((k XOR S_i) * 32'h9E3779B1) mod 2^32, where S_i = (i * 32'h85EBCA6B) mod 2^32.
- Sketch: min_i is the running minimum of h_i over all k-mers processed. After `reset_window_hasher`, every min_i is 32'hFFFFFFFF.
- Hasher:
  - Each cycle with `ready_for_hashing`=1 and `hashing_is_done`=0 processes k-mer[idx] for all i in parallel, then increments idx.
  - After idx N-1 is processed, `hashing_is_done` becomes 1 and stays 1 until `reset_window_hasher`.
  - `ready_for_hashing`=0 pauses processing with no state loss.
- Bucket for sketch element i: bucket_i = min_i[31:32-B].
- Entry storage: bucket entries are clog2(MAX_WINDOWS_IN_REFERENCE) bits wide. Each bucket has a count from 0 to BUCKET_SIZE.
- Insert (is_insert rising edge, one cycle):
  - Skipped entirely if window_id >= MAX_WINDOWS_IN_REFERENCE.
  - Otherwise, for i = 0..SKETCH_SIZE-1 in order, with the table updated sequentially within the cycle, window_id is appended to bucket_i.
  - The append is skipped if the bucket is full (the id is dropped).
  - The append is also skipped if the bucket's last entry already equals window_id, so a window never appears twice in a bucket.
- Query (is_query rising edge, one cycle):
  - For every reference id j, votes[j] += the number of i for which bucket_i contains j.
  - Counters saturate at SKETCH_SIZE*MAX_WINDOWS_IN_READ.
  - Counter width is clog2(SKETCH_SIZE*MAX_WINDOWS_IN_READ+1).
- Insert and query in the same cycle: both execute, and the query sees the table as it was before the insert.
- Argmax (each cycle `calculate_matched_window`=1):
  - `matched_window_id` is registered as the id with the maximum vote count.
  - Ties resolve to the lowest id.
  - If all votes are 0, the result is -1.
- Sketch usage: insert and query use the current sketch whether or not `hashing_is_done` is set; sequencing is the host's responsibility.

## Timing
- Resets: each reset affects only its own state and overrides any operation on the same edge.
- Hashing latency: the first edge with `ready_for_hashing`=1 processes k-mer 0. `hashing_is_done` reads 1 after exactly N edges with ready high (113 by default).
- Insert and query edge detection: the block keeps a registered previous value of `is_insert` and of `is_query`. Holding either signal high for several cycles performs exactly one operation.
- Insert and query results are visible in the table and votes on the following cycle.
- `matched_window_id`: valid one edge after `calculate_matched_window` is sampled high. It holds its value afterwards until the next calculation or `reset_stats`.

## Test plan
- Reset all, hold `ready_for_hashing` for 120 cycles -> `hashing_is_done` is 0 through edge 112 and 1 at edge 113, then stays 1. `reset_window_hasher` -> it returns to 0.
- Empty table, hash an all-A window, pulse `is_query` for 2 cycles, then `calculate_matched_window` -> `matched_window_id` = -1.
- Insert an all-A window as id 5, `reset_stats`, query all-A -> votes[5]=16 and `matched_window_id` = 5. An `is_insert` pulse held for 2 cycles creates only 1 entry per bucket.
- Insert all-A windows with ids 0..16 -> each bucket is capped at 16 entries (ids 0..15). Query all-A -> result 0 (tie broken to the lowest id), and id 16 receives 0 votes.
- Insert distinct random windows with ids 0..9, then query with window 7's data -> result 7. `reset_stats` -> -1.
- Insert with window_id=600 -> table unchanged. Assert `reset_hash_table` mid-sequence, then query -> -1.
